// File: rtl/mem_responder_pkg.sv
// Shared definitions for the CVP14 memory responder: word width, default
// parameters, request classes and the read pipeline slot format.
package mem_responder_pkg;

    localparam int              WORD_W        = 16;
    localparam int              DEF_ADDR_BITS = 10;
    localparam int              DEF_READ_LAT  = 1;
    localparam logic [WORD_W-1:0] DEF_OOR_DATA = 16'h0000;

    // What the responder decided to do with the request seen at a clock edge.
    typedef enum logic [2:0] {
        REQ_IDLE     = 3'd0,
        REQ_READ     = 3'd1,
        REQ_WRITE    = 3'd2,
        REQ_CONFLICT = 3'd3,
        REQ_OOR      = 3'd4,
        REQ_LOAD     = 3'd5
    } req_class_e;

    // One read pipeline slot: a read result, an error flag, or both.
    typedef struct packed {
        logic              valid;
        logic              err;
        logic [WORD_W-1:0] data;
    } rd_slot_t;

    // Preload wins over everything; a simultaneous RD+WR is a conflict even
    // when the address is also out of range.
    function automatic req_class_e classify(input logic rd,
                                            input logic wr,
                                            input logic lden,
                                            input logic in_range);
        req_class_e cls;
        cls = REQ_IDLE;
        if (lden)                       cls = REQ_LOAD;
        else if (rd && wr)              cls = REQ_CONFLICT;
        else if ((rd || wr) && !in_range) cls = REQ_OOR;
        else if (rd)                    cls = REQ_READ;
        else if (wr)                    cls = REQ_WRITE;
        return cls;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port word RAM: synchronous write, registered read (one clock).
// No reset: contents survive a responder reset.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_BITS];

    // Write and registered read share the one address port.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CVP14 bus. Classifies each sampled request,
// services reads/writes against mem_array, returns read data READ_LAT clocks
// after RD is sampled, flags illegal requests on Err, and counts accesses.
// READ_LAT legal range is 1..4; the CVP14 fetch path needs 1.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int                ADDR_BITS = DEF_ADDR_BITS,
    parameter int                READ_LAT  = DEF_READ_LAT,
    parameter logic [WORD_W-1:0] OOR_DATA  = DEF_OOR_DATA
) (
    input  logic                 Clk1,
    input  logic                 Reset,
    input  logic [WORD_W-1:0]    Addr,
    input  logic                 RD,
    input  logic                 WR,
    input  logic [WORD_W-1:0]    DataIn,
    output logic [WORD_W-1:0]    DataOut,
    output logic                 Valid,
    output logic                 Err,
    input  logic                 LdEn,
    input  logic [ADDR_BITS-1:0] LdAddr,
    input  logic [WORD_W-1:0]    LdData,
    output logic                 Busy,
    output logic [WORD_W-1:0]    AccCount
);

    // Addresses are never folded: any set bit above ADDR_BITS is out of range.
    logic       in_range;
    req_class_e req;

    assign in_range = (Addr[WORD_W-1:ADDR_BITS] == '0);
    assign req      = classify(RD, WR, LdEn, in_range);
    assign Busy     = LdEn;

    // RAM port: preload owns the port whenever LdEn is high. A preload is a
    // boot-time action and is honoured even under Reset; processor writes
    // are dropped by Reset.
    logic                 ram_we;
    logic                 ram_re;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [WORD_W-1:0]    ram_wdata;
    logic [WORD_W-1:0]    ram_rdata;

    assign ram_we    = LdEn || (!Reset && (req == REQ_WRITE));
    assign ram_re    = !Reset && (req == REQ_READ);
    assign ram_addr  = LdEn ? LdAddr : Addr[ADDR_BITS-1:0];
    assign ram_wdata = LdEn ? LdData : DataIn;

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem_array (
        .clk   (Clk1),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // First pipeline stage: flags registered alongside the RAM read so the
    // head slot lines up with ram_rdata one clock after the request.
    logic s0_valid;
    logic s0_err;
    logic s0_oor;

    // Register the per-request result flags (valid for reads, err for illegal).
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            s0_valid <= 1'b0;
            s0_err   <= 1'b0;
            s0_oor   <= 1'b0;
        end else begin
            s0_valid <= (req == REQ_READ) || ((req == REQ_OOR) && RD);
            s0_err   <= (req == REQ_CONFLICT) || (req == REQ_OOR);
            s0_oor   <= (req == REQ_OOR);
        end
    end

    rd_slot_t head;
    rd_slot_t tail;

    assign head.valid = s0_valid;
    assign head.err   = s0_err;
    assign head.data  = s0_oor ? OOR_DATA : ram_rdata;

    // Extra READ_LAT-1 delay stages; results stay in order, one per clock.
    generate
        if (READ_LAT == 1) begin : g_lat1
            assign tail = head;
        end else begin : g_latn
            rd_slot_t dly_q [READ_LAT-1];

            // Shift the slot chain; Reset discards every in-flight result.
            always_ff @(posedge Clk1) begin
                if (Reset) begin
                    for (int i = 0; i < READ_LAT-1; i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= head;
                    for (int i = 1; i < READ_LAT-1; i++) dly_q[i] <= dly_q[i-1];
                end
            end

            assign tail = dly_q[READ_LAT-2];
        end
    endgenerate

    // DataOut shows a fresh result in its Valid cycle and otherwise holds
    // the last one, so the hold register only captures on Valid.
    logic [WORD_W-1:0] hold_q;

    // Capture each delivered read result for display between results.
    always_ff @(posedge Clk1) begin
        if (Reset)           hold_q <= '0;
        else if (tail.valid) hold_q <= tail.data;
    end

    assign DataOut = tail.valid ? tail.data : hold_q;
    assign Valid   = tail.valid;
    assign Err     = tail.err;

    // Count accepted processor reads and writes; wraps naturally at 16 bits.
    logic [WORD_W-1:0] acc_count_q;

    // Increment once per serviced READ or WRITE.
    always_ff @(posedge Clk1) begin
        if (Reset)
            acc_count_q <= '0;
        else if ((req == REQ_READ) || (req == REQ_WRITE))
            acc_count_q <= acc_count_q + 16'd1;
    end

    assign AccCount = acc_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (READ_LAT 1 and 3) share inputs.
// A directed table, random traffic against a reference model, and a few
// hand-written sequences for latency, reset flush and counter wrap.
module tb_mem_responder;

    localparam int          AB    = 10;
    localparam logic [15:0] OOR_D = 16'h0000;

    logic        Clk1 = 1'b0;
    logic        Reset;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] DataIn;
    logic        LdEn;
    logic [AB-1:0] LdAddr;
    logic [15:0] LdData;

    logic [15:0] do1, do3, cnt1, cnt3;
    logic        v1, v3, e1, e3, b1, b3;

    always #5 Clk1 = ~Clk1;

    mem_responder #(.ADDR_BITS(AB), .READ_LAT(1), .OOR_DATA(OOR_D)) dut_l1 (
        .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR),
        .DataIn(DataIn), .DataOut(do1), .Valid(v1), .Err(e1),
        .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData), .Busy(b1),
        .AccCount(cnt1)
    );

    mem_responder #(.ADDR_BITS(AB), .READ_LAT(3), .OOR_DATA(OOR_D)) dut_l3 (
        .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR),
        .DataIn(DataIn), .DataOut(do3), .Valid(v3), .Err(e3),
        .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData), .Busy(b3),
        .AccCount(cnt3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    // Memory as a plain array; each edge produces at most one result record
    // kept in a small ring keyed by edge number. A lane with latency L shows
    // the record of edge n-L+1 after edge n unless a reset came since.
    logic [15:0] m_mem [1024];
    logic [15:0] m_cnt;
    int          n_edge     = 0;
    int          last_reset = -1;
    int          r_edge [8];
    bit          r_v [8];
    bit          r_e [8];
    logic [15:0] r_d [8];
    int          lat [2] = '{1, 3};
    logic [15:0] m_hold [2];
    bit          x_v [2];
    bit          x_e [2];
    logic [15:0] x_d [2];

    task automatic model_edge();
        int s;
        s = n_edge % 8;
        r_edge[s] = n_edge;
        r_v[s] = 1'b0;
        r_e[s] = 1'b0;
        r_d[s] = '0;
        if (Reset) begin
            last_reset = n_edge;
            m_cnt = '0;
            m_hold[0] = '0;
            m_hold[1] = '0;
            if (LdEn) m_mem[LdAddr] = LdData;
        end else if (LdEn) begin
            m_mem[LdAddr] = LdData;
        end else if (RD && WR) begin
            r_e[s] = 1'b1;
        end else if ((RD || WR) && (Addr >= 16'd1024)) begin
            r_e[s] = 1'b1;
            r_v[s] = RD;
            r_d[s] = OOR_D;
        end else if (RD) begin
            r_v[s] = 1'b1;
            r_d[s] = m_mem[Addr[AB-1:0]];
            m_cnt++;
        end else if (WR) begin
            m_mem[Addr[AB-1:0]] = DataIn;
            m_cnt++;
        end
        for (int ln = 0; ln < 2; ln++) begin
            int k;
            k = n_edge - lat[ln] + 1;
            x_v[ln] = 1'b0;
            x_e[ln] = 1'b0;
            if (k >= 0 && k > last_reset) begin
                if (r_edge[k % 8] == k) begin
                    x_v[ln] = r_v[k % 8];
                    x_e[ln] = r_e[k % 8];
                    if (r_v[k % 8]) m_hold[ln] = r_d[k % 8];
                end
            end
            x_d[ln] = m_hold[ln];
        end
        n_edge++;
    endtask

    task automatic check_model();
        chk("l1_valid", {15'd0, v1}, {15'd0, x_v[0]});
        chk("l1_err",   {15'd0, e1}, {15'd0, x_e[0]});
        chk("l1_data",  do1, x_d[0]);
        chk("l1_count", cnt1, m_cnt);
        chk("l1_busy",  {15'd0, b1}, {15'd0, LdEn});
        chk("l3_valid", {15'd0, v3}, {15'd0, x_v[1]});
        chk("l3_err",   {15'd0, e3}, {15'd0, x_e[1]});
        chk("l3_data",  do3, x_d[1]);
        chk("l3_count", cnt3, m_cnt);
        chk("l3_busy",  {15'd0, b3}, {15'd0, LdEn});
    endtask

    // One clock: inputs already driven; model the edge, sample 1 unit later.
    task automatic step(input bit do_check);
        @(posedge Clk1);
        model_edge();
        #1;
        if (do_check) check_model();
    endtask

    task automatic clear_inputs();
        Reset = 1'b0; RD = 1'b0; WR = 1'b0; Addr = '0; DataIn = '0;
        LdEn = 1'b0; LdAddr = '0; LdData = '0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          lden;
        logic [AB-1:0] ldaddr;
        logic [15:0]   lddata;
        logic          rd;
        logic          wr;
        logic [15:0]   addr;
        logic [15:0]   din;
        logic          ev;
        logic          ee;
        logic [15:0]   ed;
        logic [15:0]   ecnt;
    } vec_t;

    vec_t tbl [$];

    task automatic add_vec(input logic lden, input logic [AB-1:0] la, input logic [15:0] ld,
                           input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] din, input logic ev, input logic ee,
                           input logic [15:0] ed, input logic [15:0] ecnt);
        vec_t v;
        v.lden = lden; v.ldaddr = la; v.lddata = ld; v.rd = rd; v.wr = wr;
        v.addr = a; v.din = din; v.ev = ev; v.ee = ee; v.ed = ed; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int nw;
        logic [15:0] last_din;

        // Expected values below are for the READ_LAT=1 instance.
        //       lden la      ld        rd wr addr      din       ev ee ed        cnt
        add_vec(1, 10'h000, 16'h7A12, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'd0);
        add_vec(1, 10'h001, 16'h6B34, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'd0);
        add_vec(1, 10'h005, 16'h5555, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'd0);
        add_vec(0, 10'h000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 0, 16'h7A12, 16'd1);
        add_vec(0, 10'h000, 16'h0000, 1, 0, 16'h0001, 16'h0000, 1, 0, 16'h6B34, 16'd2);
        add_vec(0, 10'h000, 16'h0000, 0, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h6B34, 16'd3);
        add_vec(0, 10'h000, 16'h0000, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'hBEEF, 16'd4);
        add_vec(0, 10'h000, 16'h0000, 1, 1, 16'h0005, 16'h1111, 0, 1, 16'hBEEF, 16'd4);
        add_vec(0, 10'h000, 16'h0000, 1, 0, 16'h0005, 16'h0000, 1, 0, 16'h5555, 16'd5);
        add_vec(0, 10'h000, 16'h0000, 1, 0, 16'h0400, 16'h0000, 1, 1, 16'h0000, 16'd5);
        add_vec(0, 10'h000, 16'h0000, 0, 1, 16'h8000, 16'h9999, 0, 1, 16'h0000, 16'd5);
        add_vec(0, 10'h000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 0, 16'h7A12, 16'd6);
        add_vec(1, 10'h020, 16'h4242, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'h7A12, 16'd6);
        add_vec(1, 10'h021, 16'h1234, 1, 1, 16'h0005, 16'h0000, 0, 0, 16'h7A12, 16'd6);
        add_vec(0, 10'h000, 16'h0000, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'h4242, 16'd7);
        add_vec(0, 10'h000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h4242, 16'd7);

        for (int i = 0; i < 8; i++) r_edge[i] = -1;
        m_cnt = '0;
        m_hold[0] = '0;
        m_hold[1] = '0;

        // Reset: two edges, check state after the second.
        clear_inputs();
        Reset = 1'b1;
        step(0);
        step(1);
        chk("reset_valid", {15'd0, v1}, 16'd0);
        chk("reset_data",  do1, 16'h0000);
        chk("reset_count", cnt1, 16'h0000);

        // Directed table.
        for (int i = 0; i < tbl.size(); i++) begin
            clear_inputs();
            LdEn = tbl[i].lden; LdAddr = tbl[i].ldaddr; LdData = tbl[i].lddata;
            RD = tbl[i].rd; WR = tbl[i].wr; Addr = tbl[i].addr; DataIn = tbl[i].din;
            step(1);
            chk($sformatf("tbl%0d_valid", i), {15'd0, v1}, {15'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_err", i),   {15'd0, e1}, {15'd0, tbl[i].ee});
            chk($sformatf("tbl%0d_data", i),  do1, tbl[i].ed);
            chk($sformatf("tbl%0d_count", i), cnt1, tbl[i].ecnt);
            chk($sformatf("tbl%0d_busy", i),  {15'd0, b1}, {15'd0, tbl[i].lden});
        end

        // Random traffic over a preloaded window 0..63 plus out-of-range hits.
        for (int a = 0; a < 64; a++) begin
            clear_inputs();
            LdEn = 1'b1; LdAddr = AB'(a); LdData = 16'($urandom);
            step(1);
        end
        for (int i = 0; i < 400; i++) begin
            int kind;
            clear_inputs();
            kind = $urandom_range(0, 99);
            if (kind < 2) begin
                Reset = 1'b1;
                RD = 1'($urandom_range(0, 1));
                Addr = 16'($urandom_range(0, 63));
            end else if (kind < 12) begin
                LdEn = 1'b1;
                LdAddr = AB'($urandom_range(0, 63));
                LdData = 16'($urandom);
                RD = 1'($urandom_range(0, 1));
                WR = 1'($urandom_range(0, 1));
                Addr = 16'($urandom_range(0, 63));
            end else if (kind < 20) begin
                RD = 1'b1; WR = 1'b1;
                Addr = 16'($urandom_range(0, 16'hFFFF));
            end else if (kind < 30) begin
                Addr = 16'($urandom_range(16'h0400, 16'hFFFF));
                if ($urandom_range(0, 1) == 1) RD = 1'b1; else WR = 1'b1;
                DataIn = 16'($urandom);
            end else if (kind < 60) begin
                RD = 1'b1;
                Addr = 16'($urandom_range(0, 63));
            end else if (kind < 85) begin
                WR = 1'b1;
                Addr = 16'($urandom_range(0, 63));
                DataIn = 16'($urandom);
            end
            step(1);
        end

        // READ_LAT=3: three back-to-back reads return 1,2,3 on consecutive cycles.
        clear_inputs();
        LdEn = 1'b1; LdAddr = 10'h030; LdData = 16'd1; step(1);
        LdAddr = 10'h031; LdData = 16'd2; step(1);
        LdAddr = 10'h032; LdData = 16'd3; step(1);
        clear_inputs(); step(1);
        step(1);
        RD = 1'b1; Addr = 16'h0030; step(1);               // edge k
        chk("lat3_k_valid", {15'd0, v3}, 16'd0);
        Addr = 16'h0031; step(1);                          // edge k+1
        chk("lat3_k1_valid", {15'd0, v3}, 16'd0);
        Addr = 16'h0032; step(1);                          // edge k+2
        chk("lat3_k2_valid", {15'd0, v3}, 16'd1);
        chk("lat3_k2_data",  do3, 16'd1);
        clear_inputs(); step(1);                           // edge k+3
        chk("lat3_k3_valid", {15'd0, v3}, 16'd1);
        chk("lat3_k3_data",  do3, 16'd2);
        step(1);                                           // edge k+4
        chk("lat3_k4_valid", {15'd0, v3}, 16'd1);
        chk("lat3_k4_data",  do3, 16'd3);
        step(1);
        chk("lat3_k5_valid", {15'd0, v3}, 16'd0);
        chk("lat3_k5_hold",  do3, 16'd3);

        // Reset during in-flight reads: nothing comes out, DataOut cleared.
        RD = 1'b1; Addr = 16'h0030; step(1);
        Addr = 16'h0031; Reset = 1'b1; step(1);
        for (int i = 0; i < 4; i++) begin
            clear_inputs(); step(1);
            chk($sformatf("flush%0d_valid", i), {15'd0, v3}, 16'd0);
            chk($sformatf("flush%0d_data", i),  do3, 16'h0000);
        end
        chk("flush_count", cnt3, 16'h0000);

        // Counter wrap: bring the count to FFFF with writes, then one read.
        nw = int'(16'hFFFF - m_cnt);
        last_din = '0;
        for (int i = 0; i < nw; i++) begin
            clear_inputs();
            WR = 1'b1; Addr = 16'h0100; DataIn = 16'(i); last_din = 16'(i);
            step(0);
        end
        clear_inputs(); step(1);
        chk("wrap_pre_count", cnt1, 16'hFFFF);
        RD = 1'b1; Addr = 16'h0100; step(1);
        chk("wrap_count_l1", cnt1, 16'h0000);
        chk("wrap_count_l3", cnt3, 16'h0000);
        chk("wrap_data", do1, last_din);

        // Preload with a simultaneous read: ignored, Busy up, count unchanged.
        clear_inputs();
        LdEn = 1'b1; LdAddr = 10'h101; LdData = 16'hCAFE;
        RD = 1'b1; Addr = 16'h0100;
        step(1);
        chk("ld_rd_valid", {15'd0, v1}, 16'd0);
        chk("ld_rd_busy",  {15'd0, b1}, 16'd1);
        chk("ld_rd_count", cnt1, 16'h0000);
        clear_inputs(); step(1);
        chk("ld_rd_busy_off", {15'd0, b1}, 16'd0);
        step(1);
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
